// File: rtl/fsqrt_issue_stage.sv
// Issue stage for the combinational single-precision sqrt core: answers special
// operands directly and gives normal operands a fixed settle window in the core.
module fsqrt_issue_stage #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic [31:0] core_a,
   input  logic [31:0] core_result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [2:0]  out_flags
);

   typedef enum logic [1:0] {IDLE, EVAL, OUT} state_t;

   state_t      state_reg;
   logic [7:0]  counter_reg;
   logic [31:0] core_a_reg;
   logic [31:0] out_data_reg;
   logic [2:0]  out_flags_reg;
   logic        out_valid_reg;

   logic        sign;
   logic [7:0]  expo;
   logic [22:0] mant;
   logic        bypass;
   logic [31:0] byp_data;
   logic [2:0]  byp_flags;
   logic        accept;

   assign sign = in_data[31];
   assign expo = in_data[30:23];
   assign mant = in_data[22:0];

   // Precedence matters: zero/denormal ignores the sign, and a negative NaN
   // is quieted and passed through rather than replaced by the default NaN.
   always_comb begin
      bypass    = 1'b1;
      byp_data  = 32'h0000_0000;
      byp_flags = 3'b001;
      if (expo == 8'h00) begin
         byp_data  = {sign, 31'b0};
         byp_flags = (mant == 23'd0) ? 3'b001 : 3'b011;
      end else if (expo == 8'hFF && mant != 23'd0) begin
         byp_data  = in_data | 32'h0040_0000;
         byp_flags = in_data[22] ? 3'b001 : 3'b101;
      end else if (sign) begin
         byp_data  = 32'h7FC0_0000;
         byp_flags = 3'b101;
      end else if (expo == 8'hFF) begin
         byp_data  = 32'h7F80_0000;
         byp_flags = 3'b001;
      end else begin
         bypass = 1'b0;
      end
   end

   assign in_ready = (state_reg == IDLE) && reset;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg     <= IDLE;
         counter_reg   <= 8'd0;
         core_a_reg    <= 32'h0000_0000;
         out_data_reg  <= 32'h0000_0000;
         out_flags_reg <= 3'b000;
         out_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  if (bypass) begin
                     out_data_reg  <= byp_data;
                     out_flags_reg <= byp_flags;
                     out_valid_reg <= 1'b1;
                     state_reg     <= OUT;
                  end else begin
                     core_a_reg  <= in_data;
                     counter_reg <= 8'(SETTLE_CYCLES - 1);
                     state_reg   <= EVAL;
                  end
               end
            end
            EVAL: begin
               // core_result is only trusted once core_a has been stable for the full window
               if (counter_reg == 8'd0) begin
                  out_data_reg  <= core_result;
                  out_flags_reg <= 3'b000;
                  out_valid_reg <= 1'b1;
                  state_reg     <= OUT;
               end else begin
                  counter_reg <= counter_reg - 8'd1;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign core_a    = core_a_reg;
   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_flags = out_flags_reg;

endmodule

// File: tb/tb_fsqrt_issue_stage.sv
// Directed bench for fsqrt_issue_stage: special-case bypass, core settle timing,
// backpressure and mid-evaluation reset, with a stubbed sqrt core.
module tb_fsqrt_issue_stage;

   localparam int SETTLE = 4;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [31:0] core_a;
   logic [31:0] core_result;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [2:0]  out_flags;

   int n_cmp = 0;
   int n_bad = 0;

   fsqrt_issue_stage #(.SETTLE_CYCLES(SETTLE)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .core_a      (core_a),
      .core_result (core_result),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_flags   (out_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s: %h", tag, obs);
      end
   endtask

   // Present one operand for exactly one edge, then scramble in_data.
   task automatic issue(input logic [31:0] d);
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 32'hFFFF_FFFF;
   endtask

   task automatic run_core(input logic [31:0] d, input logic [31:0] stub);
      core_result = stub;
      check_val("core_rdy_before", 32'(in_ready), 32'd1);
      issue(d);
      check_val("core_rdy_drop", 32'(in_ready), 32'd0);
      for (int i = 0; i < SETTLE; i++) begin
         check_val("core_settle_valid", 32'(out_valid), 32'd0);
         check_val("core_a_held", core_a, d);
         @(posedge clk); #1;
      end
      check_val("core_out_valid", 32'(out_valid), 32'd1);
      check_val("core_out_data", out_data, stub);
      check_val("core_out_flags", 32'(out_flags), 32'd0);
   endtask

   task automatic run_bypass(input logic [31:0] d, input logic [31:0] exp_d, input logic [2:0] exp_f);
      check_val("byp_rdy_before", 32'(in_ready), 32'd1);
      issue(d);
      check_val("byp_out_valid", 32'(out_valid), 32'd1);
      check_val("byp_out_data", out_data, exp_d);
      check_val("byp_out_flags", 32'(out_flags), 32'(exp_f));
      check_val("byp_rdy_out", 32'(in_ready), 32'd0);
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_val("consume_valid", 32'(out_valid), 32'd0);
      check_val("consume_rdy", 32'(in_ready), 32'd1);
   endtask

   initial begin
      reset       = 1'b0;
      in_valid    = 1'b0;
      in_data     = 32'h0;
      out_ready   = 1'b0;
      core_result = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_in_ready", 32'(in_ready), 32'd0);
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_out_data", out_data, 32'h0);
      check_val("rst_out_flags", 32'(out_flags), 32'd0);
      check_val("rst_core_a", core_a, 32'h0);
      reset = 1'b1;
      #1;
      check_val("rst_release_rdy", 32'(in_ready), 32'd1);

      // 4.0 through the core
      run_core(32'h4080_0000, 32'h4000_0000);
      consume();

      // -4.0 is answered directly; core_a keeps the previous operand
      run_bypass(32'hC080_0000, 32'h7FC0_0000, 3'b101);
      check_val("neg_core_a_kept", core_a, 32'h4080_0000);
      consume();

      run_bypass(32'h0000_0001, 32'h0000_0000, 3'b011);
      consume();
      run_bypass(32'h8000_0001, 32'h8000_0000, 3'b011);
      consume();
      run_bypass(32'h0000_0000, 32'h0000_0000, 3'b001);
      consume();
      run_bypass(32'h7F80_0000, 32'h7F80_0000, 3'b001);
      consume();
      run_bypass(32'h7F80_0001, 32'h7FC0_0001, 3'b101);
      consume();
      run_bypass(32'h7FC1_2345, 32'h7FC1_2345, 3'b001);
      consume();
      run_bypass(32'hFF80_0000, 32'h7FC0_0000, 3'b101);
      consume();

      // 9.0 with downstream stalled for three cycles; core output wanders meanwhile
      run_core(32'h4110_0000, 32'h4040_0000);
      core_result = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_val("bp_valid", 32'(out_valid), 32'd1);
         check_val("bp_data", out_data, 32'h4040_0000);
         check_val("bp_rdy", 32'(in_ready), 32'd0);
      end
      consume();
      check_val("bp_data_after", out_data, 32'h4040_0000);

      // Reset during the second EVAL cycle drops the operand
      core_result = 32'h4080_0000;
      issue(32'h4180_0000);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check_val("mid_rst_rdy_low", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check_val("mid_rst_valid", 32'(out_valid), 32'd0);
      check_val("mid_rst_rdy", 32'(in_ready), 32'd1);
      check_val("mid_rst_data", out_data, 32'h0);
      @(posedge clk); #1;
      check_val("mid_rst_no_result", 32'(out_valid), 32'd0);

      run_core(32'h3F80_0000, 32'h3F80_0000);
      consume();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fsqrt_issue_stage.md
Name: fsqrt_issue_stage

Overview:
- Sequential front-end that sits directly upstream of the combinational single-precision square-root datapath.
- Accepts IEEE754 operands over a valid/ready handshake and filters special cases: zero, negative, infinity, NaN and denormal operands are answered directly without using the core.
- Normal positive operands are driven to the core and held for a fixed settle window; the core result is then registered and presented downstream over valid/ready.
- Gives the deep combinational core a deterministic, multicycle timing envelope.

Parameters:
- SETTLE_CYCLES, 4: number of cycles core_a is held stable before core_result is sampled. Legal range 1..255; the counter is 8 bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- in_valid  input  1  operand valid
- in_ready  output  1  stage can accept an operand
- in_data  input  32  IEEE754 single operand
- core_a  output  32  operand to sqrt core (registered)
- core_result  input  32  combinational sqrt core result
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  32  IEEE754 result
- out_flags  output  3  {invalid, denorm_flushed, bypass}

Behaviour:
- States: IDLE, EVAL, OUT.
- Reset (reset==0 at a clk edge):
  - state goes to IDLE; out_valid=0, out_data=0, out_flags=0, core_a=0, counter=0.
  - in_ready=0 while reset==0.
  - Reset asserted in any state aborts the operation in flight and discards it; no partial result is emitted.
- in_ready = (state==IDLE) && reset. Combinational from state only, never from in_valid.
- Accept occurs when in_valid && in_ready at a clk edge (call it T0).
- Classification at accept, with e=in_data[30:23], m=in_data[22:0], s=in_data[31]:
  - e==0, m==0: result {s,31'b0}; flags 001.
  - e==0, m!=0: flush to zero; result {s,31'b0}; flags 011. A negative denormal returns -0, not NaN.
  - e==255, m!=0: result in_data | 0x00400000 (quieted). Flags 101 if in_data[22]==0 (signalling NaN), else 001.
  - s==1 and e!=0 (negative nonzero, including -inf): result 0x7FC00000; flags 101.
  - s==0, e==255, m==0 (+inf): result 0x7F800000; flags 001.
  - otherwise (normal positive): core path.
- Bypass path:
  - IDLE to OUT at T0; out_data and out_flags loaded at T0.
  - out_valid=1 from T0+1 (latency 1).
- Core path:
  - At T0: core_a <= in_data, counter <= SETTLE_CYCLES-1, state goes to EVAL.
  - In EVAL, each edge: if counter==0, then out_data <= core_result, out_flags <= 000, state goes to OUT; else counter decrements.
  - out_valid rises at T0+SETTLE_CYCLES (4 cycles with the default).
  - core_a is held constant throughout EVAL and OUT, and keeps its last value in IDLE.
- OUT:
  - out_valid=1; out_data and out_flags are held stable until out_valid && out_ready at an edge.
  - On that edge: state goes to IDLE, out_valid=0.
  - out_data and out_flags keep their last values after the handshake.
  - in_ready stays 0 during OUT, so an operand can never be accepted on the same edge a result is consumed. The minimum issue interval is SETTLE_CYCLES+2 cycles for the core path and 2 cycles for the bypass path, assuming out_ready is held high.
- in_valid while the stage is not ready is ignored. The upstream must hold the operand until the handshake; the stage does not latch it early.
- core_result is sampled only on the final EVAL edge; changes to it at any other time have no effect.
- Signed exponent, mantissa and NaN payload bits pass through unchanged except where stated above; the stage performs no arithmetic beyond classification and the counter.

Test Plan:
- in_data=0x40800000 (4.0); core stubbed to return 0x40000000 -> in_ready drops at T0+1; core_a=0x40800000 held for 4 cycles; out_valid=1 at T0+4 with out_data=0x40000000, flags=000.
- in_data=0xC0800000 (-4.0) -> out_valid at T0+1, out_data=0x7FC00000, flags=101; core_a unchanged.
- in_data=0x00000001 then 0x80000001 -> out_data=0x00000000 then 0x80000000, flags=011 both; +0 (0x00000000) -> 0x00000000, flags=001.
- in_data=0x7F800000 -> 0x7F800000, flags 001; in_data=0x7F800001 -> 0x7FC00001, flags 101; in_data=0x7FC12345 -> 0x7FC12345, flags 001.
- Backpressure: 9.0 (0x41100000), stub returns 0x40400000, out_ready low for 3 cycles after out_valid -> out_data and out_valid stable, in_ready=0 throughout; handshake on the 4th cycle; in_ready=1 the next cycle.
- reset=0 for one edge in the second EVAL cycle -> out_valid never rises for that operand; next cycle in_ready=1 and out_data=0; a new operand 1.0 (0x3F800000, stub 0x3F800000) completes normally with SETTLE_CYCLES latency.
